// File: rtl/cs_rr_scheduler_if.sv
// Request/grant bundle between eight requesters and the chip-select scheduler.
// The master modport is the requester side; the slave modport is the scheduler.
interface cs_rr_scheduler_if;
  logic [7:0] REQ;
  logic [2:0] SEL;
  logic       EN;
  logic [7:0] GNT_N;
  logic       BUSY;

  modport master (
    output REQ,
    input  SEL,
    input  EN,
    input  GNT_N,
    input  BUSY
  );

  modport slave (
    input  REQ,
    output SEL,
    output EN,
    output GNT_N,
    output BUSY
  );
endinterface

// File: rtl/cs_rr_scheduler.sv
// Round-robin owner of a shared 3-to-8 active-low chip-select decoder; 1 cycle REQ->grant.
// No backpressure: REQ is a level held by each requester, tenure bounded by MAX_HOLD.
module cs_rr_scheduler #(
  parameter int MAX_HOLD   = 16,
  parameter int GAP_CYCLES = 1
) (
  input logic              clk,
  input logic              rst_n,
  cs_rr_scheduler_if.slave bus
);

  localparam logic [7:0] LP_MAX_HOLD = 8'(MAX_HOLD);
  localparam logic [3:0] LP_GAP      = 4'(GAP_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t     r_state;
  logic [2:0] r_ptr;
  logic [7:0] r_hold;
  logic [3:0] r_gap;
  logic [2:0] r_sel;
  logic       r_en;
  logic [7:0] r_gnt_n;
  logic       r_busy;

  logic       w_found;
  logic [2:0] w_win;
  logic [2:0] w_idx;

  // Rotating priority search: first requester at or after r_ptr, wrapping 7->0.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      w_idx = r_ptr + 3'(k);
      if (!w_found && bus.REQ[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= 3'd0;
      r_hold  <= 8'd0;
      r_gap   <= 4'd0;
      r_sel   <= 3'd0;
      r_en    <= 1'b0;
      r_gnt_n <= 8'hFF;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state <= ST_GRANT;
            r_sel   <= w_win;
            r_en    <= 1'b1;
            r_gnt_n <= ~(8'd1 << w_win);
            r_busy  <= 1'b1;
            r_hold  <= 8'd1;
          end
        end
        ST_GRANT: begin
          if (bus.REQ[r_sel] && (r_hold < LP_MAX_HOLD)) begin
            r_hold <= r_hold + 8'd1;
          end else begin
            // Timeout and voluntary release share this path; SEL is kept through GAP.
            r_state <= ST_GAP;
            r_en    <= 1'b0;
            r_gnt_n <= 8'hFF;
            r_gap   <= 4'd1;
            r_hold  <= 8'd0;
            r_ptr   <= r_sel + 3'd1;
          end
        end
        ST_GAP: begin
          if (r_gap == LP_GAP) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_gap   <= 4'd0;
          end else begin
            r_gap <= r_gap + 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_en    <= 1'b0;
          r_gnt_n <= 8'hFF;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.SEL   = r_sel;
  assign bus.EN    = r_en;
  assign bus.GNT_N = r_gnt_n;
  assign bus.BUSY  = r_busy;

endmodule

// File: tb/tb_cs_rr_scheduler.sv
// Directed bench: instance A uses default parameters, instance B uses MAX_HOLD=4.
module tb_cs_rr_scheduler;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  cs_rr_scheduler_if a_if ();
  cs_rr_scheduler_if b_if ();

  cs_rr_scheduler #(.MAX_HOLD(16), .GAP_CYCLES(1)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if)
  );

  cs_rr_scheduler #(.MAX_HOLD(4), .GAP_CYCLES(1)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic [2:0] sel;
    logic       en;
    logic [7:0] gnt_n;
    logic       busy;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [2:0] sel, input logic en,
                       input logic [7:0] gnt_n, input logic busy,
                       input logic [2:0] e_sel, input logic e_en,
                       input logic [7:0] e_gnt_n, input logic e_busy);
    n_chk++;
    if (sel !== e_sel || en !== e_en || gnt_n !== e_gnt_n || busy !== e_busy) begin
      n_err++;
      $display("FAIL %s: got SEL=%0d EN=%b GNT_N=%h BUSY=%b, want SEL=%0d EN=%b GNT_N=%h BUSY=%b",
               name, sel, en, gnt_n, busy, e_sel, e_en, e_gnt_n, e_busy);
    end
  endtask

  initial begin
    logic       ok;
    logic [2:0] e_sel;
    logic       e_en;
    logic       e_busy;
    int         ph;

    n_chk = 0;
    n_err = 0;

    // Single grant, ignored side requests, ptr advance, then wrap from ptr=7 with 0x43.
    vecs[0]  = '{8'h20, 3'd5, 1'b1, 8'hDF, 1'b1};
    vecs[1]  = '{8'h20, 3'd5, 1'b1, 8'hDF, 1'b1};
    vecs[2]  = '{8'h21, 3'd5, 1'b1, 8'hDF, 1'b1};
    vecs[3]  = '{8'h20, 3'd5, 1'b1, 8'hDF, 1'b1};
    vecs[4]  = '{8'h20, 3'd5, 1'b1, 8'hDF, 1'b1};
    vecs[5]  = '{8'h00, 3'd5, 1'b0, 8'hFF, 1'b1};
    vecs[6]  = '{8'h00, 3'd5, 1'b0, 8'hFF, 1'b0};
    vecs[7]  = '{8'h41, 3'd6, 1'b1, 8'hBF, 1'b1};
    vecs[8]  = '{8'h00, 3'd6, 1'b0, 8'hFF, 1'b1};
    vecs[9]  = '{8'h00, 3'd6, 1'b0, 8'hFF, 1'b0};
    vecs[10] = '{8'h43, 3'd0, 1'b1, 8'hFE, 1'b1};
    vecs[11] = '{8'h42, 3'd0, 1'b0, 8'hFF, 1'b1};
    vecs[12] = '{8'h43, 3'd0, 1'b0, 8'hFF, 1'b0};
    vecs[13] = '{8'h43, 3'd1, 1'b1, 8'hFD, 1'b1};
    vecs[14] = '{8'h41, 3'd1, 1'b0, 8'hFF, 1'b1};
    vecs[15] = '{8'h43, 3'd1, 1'b0, 8'hFF, 1'b0};
    vecs[16] = '{8'h43, 3'd6, 1'b1, 8'hBF, 1'b1};
    vecs[17] = '{8'h00, 3'd6, 1'b0, 8'hFF, 1'b1};
    vecs[18] = '{8'h00, 3'd6, 1'b0, 8'hFF, 1'b0};

    rst_n    = 1'b0;
    a_if.REQ = 8'h00;
    b_if.REQ = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", a_if.SEL, a_if.EN, a_if.GNT_N, a_if.BUSY, 3'd0, 1'b0, 8'hFF, 1'b0);
    check("reset_b", b_if.SEL, b_if.EN, b_if.GNT_N, b_if.BUSY, 3'd0, 1'b0, 8'hFF, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("idle_noreq", a_if.SEL, a_if.EN, a_if.GNT_N, a_if.BUSY, 3'd0, 1'b0, 8'hFF, 1'b0);
    end

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      a_if.REQ = vecs[i].req;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), a_if.SEL, a_if.EN, a_if.GNT_N, a_if.BUSY,
            vecs[i].sel, vecs[i].en, vecs[i].gnt_n, vecs[i].busy);
    end

    // Fairness on B: 4 cycles granted, 1 GAP, 1 IDLE, alternating 0 and 7.
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      b_if.REQ = 8'h81;
      @(posedge clk);
      #1;
      ph     = c % 6;
      e_sel  = ((c / 6) % 2 == 0) ? 3'd0 : 3'd7;
      e_en   = (ph < 4);
      e_busy = (ph < 5);
      check($sformatf("rr_c%0d", c), b_if.SEL, b_if.EN, b_if.GNT_N, b_if.BUSY,
            e_sel, e_en, e_en ? ~(8'd1 << e_sel) : 8'hFF, e_busy);
    end
    @(negedge clk);
    b_if.REQ = 8'h00;

    // Timeout on A: 16 granted, GAP, IDLE, regrant to 3.
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      a_if.REQ = 8'h08;
      @(posedge clk);
      #1;
      ph     = c % 18;
      e_en   = (ph < 16);
      e_busy = (ph < 17);
      check($sformatf("tmo_c%0d", c), a_if.SEL, a_if.EN, a_if.GNT_N, a_if.BUSY,
            3'd3, e_en, e_en ? 8'hF7 : 8'hFF, e_busy);
    end

    @(negedge clk);
    a_if.REQ = 8'h04;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (a_if.EN === 1'b1 && a_if.SEL === 3'd2) begin
        ok = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL grant_sel2_wait: got SEL=%0d EN=%b, want SEL=2 EN=1 within 10 cycles",
               a_if.SEL, a_if.EN);
    end

    // Asynchronous reset between edges must clear outputs with no clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", a_if.SEL, a_if.EN, a_if.GNT_N, a_if.BUSY, 3'd0, 1'b0, 8'hFF, 1'b0);
    a_if.REQ = 8'h0C;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_grant", a_if.SEL, a_if.EN, a_if.GNT_N, a_if.BUSY, 3'd2, 1'b1, 8'hFB, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
